// File: rtl/reg_wb_bank.sv
// Writeback register bank: a 2-entry in-order {addr, data} buffer draining into
// sixteen WIDTH-bit architectural registers, one commit per cycle.
module reg_wb_bank #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             commit_en,
    input  logic             flush,
    output logic [15:0]      busy,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7,
    output logic [WIDTH-1:0] r8,
    output logic [WIDTH-1:0] r9,
    output logic [WIDTH-1:0] r10,
    output logic [WIDTH-1:0] r11,
    output logic [WIDTH-1:0] r12,
    output logic [WIDTH-1:0] r13,
    output logic [WIDTH-1:0] r14,
    output logic [WIDTH-1:0] r15
);

    logic [3:0]       buf_addr_q [2];
    logic [3:0]       buf_addr_d [2];
    logic [WIDTH-1:0] buf_data_q [2];
    logic [WIDTH-1:0] buf_data_d [2];
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] regs_q [16];
    logic [WIDTH-1:0] regs_d [16];

    logic             push, pop;
    logic [15:0]      busy_term [2];

    // Ready depends on registered occupancy only, never on this cycle's inputs.
    assign wr_ready = (count_q != 2'd2);
    assign push     = wr_valid && wr_ready && !flush;
    assign pop      = (count_q != 2'd0) && commit_en && !flush;

    always_comb begin
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        regs_d     = regs_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                buf_addr_d[tail_q] = wr_addr;
                buf_data_d[tail_q] = wr_data;
                tail_d             = ~tail_q;
            end
            if (pop) begin
                regs_d[buf_addr_q[head_q]] = buf_data_q[head_q];
                head_d                     = ~head_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_addr_q[i] <= '0;
                buf_data_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            regs_q     <= regs_d;
        end
    end

    // Slot e is live when the buffer is full, or it is the head of a single entry.
    for (genvar gi = 0; gi < 2; gi++) begin : g_busy
        logic ent_vld;
        assign ent_vld       = (count_q == 2'd2) || ((count_q == 2'd1) && (head_q == 1'(gi)));
        assign busy_term[gi] = ent_vld ? (16'd1 << buf_addr_q[gi]) : 16'd0;
    end

    assign busy = busy_term[0] | busy_term[1];

    assign r0  = regs_q[0];
    assign r1  = regs_q[1];
    assign r2  = regs_q[2];
    assign r3  = regs_q[3];
    assign r4  = regs_q[4];
    assign r5  = regs_q[5];
    assign r6  = regs_q[6];
    assign r7  = regs_q[7];
    assign r8  = regs_q[8];
    assign r9  = regs_q[9];
    assign r10 = regs_q[10];
    assign r11 = regs_q[11];
    assign r12 = regs_q[12];
    assign r13 = regs_q[13];
    assign r14 = regs_q[14];
    assign r15 = regs_q[15];

endmodule

// File: tb/tb_reg_wb_bank.sv
// Bench for reg_wb_bank: directed scenarios plus a random run, all compared
// against a queue-based scoreboard of pending writes and a register model.
module tb_reg_wb_bank;

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid, commit_en, flush;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] busy;
    logic [15:0] r_w [16];

    entry_t      sb_q [$];
    logic [15:0] exp_r [16];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    reg_wb_bank #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit_en(commit_en), .flush(flush),
        .busy(busy),
        .r0(r_w[0]),   .r1(r_w[1]),   .r2(r_w[2]),   .r3(r_w[3]),
        .r4(r_w[4]),   .r5(r_w[5]),   .r6(r_w[6]),   .r7(r_w[7]),
        .r8(r_w[8]),   .r9(r_w[9]),   .r10(r_w[10]), .r11(r_w[11]),
        .r12(r_w[12]), .r13(r_w[13]), .r14(r_w[14]), .r15(r_w[15])
    );

    function automatic logic [15:0] busy_model();
        logic [15:0] b = 16'h0;
        foreach (sb_q[i]) b |= (16'd1 << sb_q[i].a);
        return b;
    endfunction

    // One clock: decide acceptance/commit from the pre-edge inputs, then
    // advance the scoreboard after the edge.
    task automatic step();
        bit acc, pp;
        entry_t e;
        acc = wr_valid && (sb_q.size() != 2) && !flush;
        pp  = (sb_q.size() != 0) && commit_en && !flush;
        e.a = wr_addr;
        e.d = wr_data;
        @(posedge clk);
        #1;
        if (flush) sb_q.delete();
        else begin
            if (pp) begin
                entry_t h = sb_q.pop_front();
                exp_r[h.a] = h.d;
            end
            if (acc) sb_q.push_back(e);
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] a, input logic [15:0] d,
                         input bit c, input bit f);
        wr_valid  = v;
        wr_addr   = a;
        wr_data   = d;
        commit_en = c;
        flush     = f;
    endtask

    task automatic test_reset();
        drive(0, 4'd0, 16'h0, 0, 0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            exp_r[i] = 16'h0;
            checks++;
            if (r_w[i] !== 16'h0) begin
                errors++;
                $display("FAIL reset_r%0d got %h exp 0000", i, r_w[i]);
            end
        end
        checks++;
        if (busy !== 16'h0) begin errors++; $display("FAIL reset_busy got %h exp 0000", busy); end
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", wr_ready); end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_single();
        drive(1, 4'd3, 16'hBEEF, 1, 0);
        step();
        drive(0, 4'd0, 16'h0, 1, 0);
        checks++;
        if (busy !== 16'h0008) begin errors++; $display("FAIL single_busy got %h exp 0008", busy); end
        checks++;
        if (r_w[3] !== 16'h0000) begin errors++; $display("FAIL single_nobypass got %h exp 0000", r_w[3]); end
        step();
        checks++;
        if (r_w[3] !== 16'hBEEF) begin errors++; $display("FAIL single_r3 got %h exp beef", r_w[3]); end
        checks++;
        if (busy !== 16'h0) begin errors++; $display("FAIL single_busy_clr got %h exp 0000", busy); end
        $display("test_single r3=%h busy=%h", r_w[3], busy);
    endtask

    task automatic test_stall();
        drive(1, 4'd1, 16'h1111, 0, 0); step();
        drive(1, 4'd2, 16'h2222, 0, 0); step();
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", wr_ready); end
        checks++;
        if (busy !== 16'h0006) begin errors++; $display("FAIL stall_busy got %h exp 0006", busy); end
        drive(1, 4'd4, 16'h4444, 0, 0); step();
        checks++;
        if (busy !== 16'h0006) begin errors++; $display("FAIL stall_third_busy got %h exp 0006", busy); end
        drive(0, 4'd0, 16'h0, 1, 0); step();
        checks++;
        if (r_w[1] !== 16'h1111 || r_w[2] !== exp_r[2]) begin
            errors++; $display("FAIL stall_first r1=%h r2=%h exp 1111 %h", r_w[1], r_w[2], exp_r[2]);
        end
        step();
        checks++;
        if (r_w[2] !== 16'h2222) begin errors++; $display("FAIL stall_second got %h exp 2222", r_w[2]); end
        step();
        checks++;
        if (r_w[4] !== 16'h0000 || busy !== 16'h0) begin
            errors++; $display("FAIL stall_ignored r4=%h busy=%h exp 0000 0000", r_w[4], busy);
        end
        $display("test_stall r1=%h r2=%h r4=%h", r_w[1], r_w[2], r_w[4]);
    endtask

    task automatic test_same_addr();
        drive(1, 4'd5, 16'h0001, 0, 0); step();
        drive(1, 4'd5, 16'h0002, 0, 0); step();
        drive(0, 4'd0, 16'h0, 1, 0); step();
        checks++;
        if (r_w[5] !== 16'h0001) begin errors++; $display("FAIL same_first got %h exp 0001", r_w[5]); end
        checks++;
        if (busy !== 16'h0020) begin errors++; $display("FAIL same_busy got %h exp 0020", busy); end
        step();
        checks++;
        if (r_w[5] !== 16'h0002) begin errors++; $display("FAIL same_second got %h exp 0002", r_w[5]); end
        checks++;
        if (busy !== 16'h0) begin errors++; $display("FAIL same_busy_clr got %h exp 0000", busy); end
        $display("test_same_addr r5=%h", r_w[5]);
    endtask

    task automatic test_flush();
        drive(1, 4'd7, 16'hAAAA, 0, 0); step();
        drive(1, 4'd8, 16'hBBBB, 0, 0); step();
        drive(1, 4'd9, 16'hCCCC, 1, 1); step();
        drive(0, 4'd0, 16'h0, 1, 0);
        checks++;
        if (busy !== 16'h0) begin errors++; $display("FAIL flush_busy got %h exp 0000", busy); end
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", wr_ready); end
        step();
        for (int i = 7; i <= 9; i++) begin
            checks++;
            if (r_w[i] !== 16'h0000) begin errors++; $display("FAIL flush_r%0d got %h exp 0000", i, r_w[i]); end
        end
        $display("test_flush busy=%h ready=%b", busy, wr_ready);
    endtask

    task automatic test_stream();
        drive(1, 4'd10, 16'h1000, 0, 0); step();
        drive(1, 4'd11, 16'h1001, 0, 0); step();
        for (int n = 0; n < 20; n++) begin
            drive(1, 4'(n), 16'h2000 + 16'(n), 1, 0);
            step();
            checks++;
            if (wr_ready !== (sb_q.size() != 2) || busy !== busy_model()) begin
                errors++;
                $display("FAIL stream_ctl cyc%0d ready=%b busy=%h exp %b %h", n, wr_ready, busy, sb_q.size() != 2, busy_model());
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (r_w[i] !== exp_r[i]) begin errors++; $display("FAIL stream_r%0d cyc%0d got %h exp %h", i, n, r_w[i], exp_r[i]); end
            end
        end
        drive(0, 4'd0, 16'h0, 1, 0); step(); step();
        $display("test_stream pending=%0d", sb_q.size());
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            step();
            checks++;
            if (wr_ready !== (sb_q.size() != 2) || busy !== busy_model()) begin
                errors++;
                $display("FAIL rand_ctl cyc%0d ready=%b busy=%h exp %b %h", n, wr_ready, busy, sb_q.size() != 2, busy_model());
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (r_w[i] !== exp_r[i]) begin errors++; $display("FAIL rand_r%0d cyc%0d got %h exp %h", i, n, r_w[i], exp_r[i]); end
            end
        end
        $display("test_random done");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 4'(i), 16'h5A00 | 16'(i + 1), 1, 0);
            step();
        end
        drive(1, 4'd6, 16'h6666, 0, 0); step();
        drive(1, 4'd12, 16'hCCCC, 0, 0); step();
        drive(0, 4'd0, 16'h0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        sb_q.delete();
        for (int i = 0; i < 16; i++) begin
            exp_r[i] = 16'h0;
            checks++;
            if (r_w[i] !== 16'h0) begin errors++; $display("FAIL areset_r%0d got %h exp 0000", i, r_w[i]); end
        end
        checks++;
        if (busy !== 16'h0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL areset_ctl busy=%h ready=%b exp 0000 1", busy, wr_ready);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1, 4'd14, 16'hE0E0, 1, 0); step();
        drive(0, 4'd0, 16'h0, 1, 0);
        checks++;
        if (busy !== 16'h4000) begin errors++; $display("FAIL postreset_busy got %h exp 4000", busy); end
        step();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (r_w[i] !== exp_r[i]) begin errors++; $display("FAIL postreset_r%0d got %h exp %h", i, r_w[i], exp_r[i]); end
        end
        $display("test_async_reset r14=%h", r_w[14]);
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_same_addr();
        test_flush();
        test_stream();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_wb_bank.md
REG_WB_BANK -- requirements
Module: reg_wb_bank

Interface
REQ-001: Parameter WIDTH, default 16, register and write-data width in bits.
REQ-002: clk  input  1  system clock; all state updates on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: wr_valid  input  1  writeback request valid.
REQ-005: wr_ready  output  1  block can accept a request this cycle.
REQ-006: wr_addr  input  4  destination register index, 0-15.
REQ-007: wr_data  input  WIDTH  value to write.
REQ-008: commit_en  input  1  permits the head buffer entry to commit this cycle.
REQ-009: flush  input  1  synchronous discard of all buffered, uncommitted writes.
REQ-010: busy  output  16  bit i high while any buffered entry targets register i.
REQ-011: r0 .. r15  output  WIDTH each  committed register contents; these feed the 16:1 operand select mux directly.

Function
REQ-012: The block SHALL hold a 2-entry in-order write buffer (FIFO) of {addr, data} pairs and 16 WIDTH-bit registers.
REQ-013: wr_ready SHALL equal (buffered entry count != 2), decoded from registered state only, with no combinational path from wr_valid, commit_en or flush.
REQ-014: Push: on a rising edge with wr_valid=1, wr_ready=1 and flush=0, {wr_addr, wr_data} SHALL be appended at the tail.
REQ-015: wr_valid while wr_ready=0 SHALL be ignored; no state change, no data loss of buffered entries.
REQ-016: Pop: on a rising edge with count>0, commit_en=1 and flush=0, the head entry's data SHALL be written to register r[addr] and the entry removed.
REQ-017: Exactly one register write per cycle maximum; the other 15 registers SHALL hold.
REQ-018: Simultaneous push and pop SHALL leave count unchanged and preserve order; a push to a full buffer in the same cycle as a pop is NOT accepted, since wr_ready was 0.
REQ-019: Latency: a write accepted at edge k into an empty buffer SHALL appear on r[addr] after edge k+1 if commit_en=1 at that edge; the earliest visibility is one cycle after acceptance.
REQ-020: commit_en=0 SHALL stall commits indefinitely; buffered entries and busy are held.
REQ-021: Two buffered entries to the same address SHALL commit in order; the final register value is the later entry's data.
REQ-022: busy SHALL be the OR of the one-hot decodes of the valid entries' addresses, derived from registered buffer state; busy[i] clears on the edge that commits or flushes the last entry targeting i.
REQ-023: flush=1 at an edge SHALL empty the buffer, suppress that cycle's commit and push, and leave r0-r15 unchanged.
REQ-024: Read-during-write: r outputs SHALL show the pre-edge value until the commit edge; there is no bypass.
REQ-025: Buffer pointers SHALL wrap modulo 2; count SHALL never exceed 2 or underflow below 0.

Reset
REQ-026: While rst_n=0, the block SHALL immediately force r0-r15=0, buffer count=0, pointers=0, busy=16'h0000 and wr_ready=1, regardless of clk.
REQ-027: Reset asserted mid-operation SHALL discard all buffered entries; no partial commit occurs.
REQ-028: On the first edge after rst_n deasserts, the block SHALL accept pushes normally.

Verification
REQ-029: Reset, then push addr=3 data=16'hBEEF with commit_en=1 -> busy=16'h0008 for one cycle, r3=16'hBEEF one cycle after acceptance, busy=0.
REQ-030: commit_en=0, push addr=1 then addr=2 -> wr_ready=0 and busy=16'h0006; a third push is ignored; raising commit_en -> r1 then r2 update on consecutive edges.
REQ-031: Full buffer, commit_en=1, wr_valid=1 held -> one pop and one push per cycle in steady state, order preserved, count stays within 1-2.
REQ-032: Buffered addr=5 data=1 then addr=5 data=2 -> r5=1 after the first commit, r5=2 after the second; busy[5] clears only after the second.
REQ-033: Two buffered entries, assert flush with commit_en=1 -> no register changes, busy=0, wr_ready=1 on the next cycle.
REQ-034: r0-r15 loaded with nonzero values, then rst_n pulsed low between clock edges -> all outputs 0 immediately, before the next clk edge.
